inv_sub_bytes_seq: RTL and testbench



---
 rtl/inv_sub_bytes_seq.sv | 110 +++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per cycle; result valid N=16/B cycles after accept.
// Result held in DONE while out_ready=0; a new block is accepted only in IDLE or as the result leaves DONE.
module inv_sub_bytes_seq #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int N  = 16 / BYTES_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [127:0]    st, st_nxt;
   logic            load;
   logic [6:0]      lane_lsb [BYTES_PER_CYCLE];
   logic [7:0]      sub_in   [BYTES_PER_CYCLE];
   logic [7:0]      sub_out  [BYTES_PER_CYCLE];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8), and maps 0 to 0 without a special case
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] inv_s(input logic [7:0] a);
      logic [7:0] b;
      b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
      assign lane_lsb[j] = 7'(120 - 8 * (int'(cnt) * BYTES_PER_CYCLE + j));
      assign sub_in[j]   = st[lane_lsb[j] +: 8];
      assign sub_out[j]  = inv_s(sub_in[j]);
   end

   always_comb begin
      st_nxt = st;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         st_nxt[lane_lsb[j] +: 8] = sub_out[j];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (cnt == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
   end

   assign load     = in_valid && in_ready;
   assign out_data = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= '0;
         cnt <= '0;
      end else if (load) begin
         st  <= in_data;
         cnt <= '0;
      end else if (state == BUSY) begin
         st  <= st_nxt;
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: reset, known vectors, full byte sweep, backpressure, streaming, reset mid-BUSY, round trip at every width.
module tb_inv_sub_bytes_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   logic         x_ordy;
   logic         x_irdy [4];
   logic         x_vld  [4];
   logic [127:0] x_dat  [4];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   inv_sub_bytes_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_b1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_irdy[0]), .in_data(in_data),
      .out_valid(x_vld[0]), .out_ready(x_ordy), .out_data(x_dat[0]));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(2)) u_b2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_irdy[1]), .in_data(in_data),
      .out_valid(x_vld[1]), .out_ready(x_ordy), .out_data(x_dat[1]));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(8)) u_b8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_irdy[2]), .in_data(in_data),
      .out_valid(x_vld[2]), .out_ready(x_ordy), .out_data(x_dat[2]));
   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_b16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_irdy[3]), .in_data(in_data),
      .out_valid(x_vld[3]), .out_ready(x_ordy), .out_data(x_dat[3]));

   // Forward S-box model: brute-force inverse then the forward affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] fwd_s(input logic [7:0] a);
      logic [7:0] b;
      b = 8'h00;
      for (int c = 1; c < 256; c++) begin
         if (gmul(a, 8'(c)) == 8'h01) b = 8'(c);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] fwd_block(input logic [127:0] x);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fwd_s(x[127-8*i -: 8]);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one block while the DUT is idle; returns just after the accepting edge.
   task automatic send(input logic [127:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid; checks latency in cycles after the accepting edge and the data.
   task automatic wait_res(input string tag, input logic [127:0] exp, input int lat);
      int cyc;
      cyc = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         cyc++;
         if (out_valid) break;
      end
      chkb({tag, "_vld"}, out_valid, 1'b1);
      chki({tag, "_lat"}, cyc - 1, lat);
      chk({tag, "_dat"}, out_data, exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [127:0] blk [16];
      logic [127:0] exp [16];
      logic [127:0] x;
      int tx, rx, cy, last_cy;
      logic hs;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; x_ordy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_data", out_data, 128'h0);

      send(128'h0);
      wait_res("zero", {16{8'h52}}, 4);

      send(128'h00010203_04050607_08090a0b_0c0d0e0f);
      wait_res("row0", 128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 4);

      send(128'h637ced16_ca637ced_16ca637c_ed16ca63);
      wait_res("known", 128'h000153ff_10000153_ff100001_53ff1000, 4);

      // Streaming sweep of all 256 byte values, in_valid and out_ready held high.
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) begin
            exp[b][127-8*i -: 8] = 8'(16 * b + i);
         end
         blk[b] = fwd_block(exp[b]);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tx = 0; rx = 0; cy = 0; last_cy = 0;
      in_valid = 1'b1;
      in_data  = blk[0];
      for (int k = 0; k < 200 && rx < 16; k++) begin
         #1;
         hs = in_ready && in_valid;
         if (out_valid) begin
            chk($sformatf("stream_dat%0d", rx), out_data, exp[rx]);
            if (rx > 0) chki($sformatf("stream_gap%0d", rx), cy - last_cy, 5);
            last_cy = cy;
            rx++;
         end
         @(posedge clk); #1;
         if (hs) begin
            tx++;
            if (tx >= 16) in_valid = 1'b0;
            else          in_data  = blk[tx];
         end
         @(negedge clk);
         cy++;
      end
      in_valid = 1'b0;
      chki("stream_count", rx, 16);
      @(posedge clk); #1;

      // Backpressure: result held and new data refused until out_ready rises.
      out_ready = 1'b0;
      send(128'h00010203_04050607_08090a0b_0c0d0e0f);
      wait_res("bp_a", 128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 4);
      in_valid = 1'b1;
      in_data  = 128'h0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chkb("bp_hold_vld", out_valid, 1'b1);
         chkb("bp_hold_rdy", in_ready, 1'b0);
         chk("bp_hold_dat", out_data, 128'h52096ad5_3036a538_bf40a39e_81f3d7fb);
      end
      out_ready = 1'b1;
      #1 chkb("bp_release_rdy", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chkb("bp_taken_vld", out_valid, 1'b0);
      wait_res("bp_b", {16{8'h52}}, 4);
      @(posedge clk); #1;

      // Reset during the second BUSY cycle.
      send(128'h00010203_04050607_08090a0b_0c0d0e0f);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chkb("midrst_out_valid", out_valid, 1'b0);
      chkb("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_data", out_data, 128'h0);
      @(posedge clk); #1;
      send({16{8'h63}});
      wait_res("midrst_next", 128'h0, 4);

      // Round trip through forward SubBytes at every width.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      x = {$urandom, $urandom, $urandom, $urandom};
      send(fwd_block(x));
      wait_res("rt_b4", x, 4);
      repeat (20) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chkb($sformatf("rt_x%0d_vld", k), x_vld[k], 1'b1);
         chk($sformatf("rt_x%0d_dat", k), x_dat[k], x);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
